// File: rtl/processor_pkg.sv
// Shared processor definitions: fetch FSM state encodings and the default
// address and count widths used by the fetch sequencer and the core.
package processor_pkg;

  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_CNT_W  = 16;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DONE  = 2'd2
  } fetch_state_e;

endpackage : processor_pkg

// File: rtl/fetch_sequencer_pc_next.sv
// pc_next: combinational next-PC select for the fetch sequencer.
// The branch redirect wins over the sequential +INCR step; with neither
// request the PC holds.
module pc_next #(
  parameter int ADDR_W = 16,
  parameter int INCR   = 1
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              advance,
  input  logic              branch,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] next_pc
);

  // Select hold / redirect / sequential step; the add wraps modulo 2^ADDR_W.
  always_comb begin
    // NOTE: the default assignment first guarantees next_pc is driven on
    // every path, so no latch is inferred.
    next_pc = pc;
    if (branch) begin
      next_pc = target;
    end else if (advance) begin
      next_pc = pc + ADDR_W'(INCR);
    end
  end

endmodule : pc_next

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: clocked program-counter fetch engine feeding instruction
// memory. A start pulse launches a run from RESET_ADDR; each accepted
// request (fetch_valid & fetch_ready) advances the PC by INCR and bumps
// fetch_count. A non-zero fetch_limit ends the run in DONE; a zero limit
// runs until reset. stall masks fetch_valid and freezes PC and count.
// Optional feature: define FETCH_BRANCH_EN to let branch_valid/branch_target
// redirect the PC while in FETCH; without it both inputs are ignored.
module fetch_sequencer
  import processor_pkg::*;
#(
  parameter int              ADDR_W     = FETCH_ADDR_W,
  parameter int              INCR       = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int              CNT_W      = FETCH_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  fetch_limit,
  input  logic              stall,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_address,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              busy,
  output logic              done,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target
);

  fetch_state_e      state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, pc_seq;
  logic [CNT_W-1:0]  count, count_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic              done_q, done_d;
  logic              accept;
  logic              start_go;
  logic              branch_take;

  assign busy          = (state == FS_FETCH);
  assign fetch_valid   = busy & ~stall;
  assign accept        = fetch_valid & fetch_ready;
  assign fetch_address = pc;
  assign fetch_count   = count;
  assign done          = done_q;

`ifdef FETCH_BRANCH_EN
  // Redirects are honoured only during a run, stalled or not.
  assign branch_take = busy & branch_valid;
`else
  logic unused_branch_valid;
  assign unused_branch_valid = branch_valid;
  assign branch_take         = 1'b0;
`endif

  pc_next #(
    .ADDR_W (ADDR_W),
    .INCR   (INCR)
  ) u_pc_next (
    .pc      (pc),
    .advance (accept),
    .branch  (branch_take),
    .target  (branch_target),
    .next_pc (pc_seq)
  );

  // A run start reloads the PC; otherwise take pc_next's choice.
  assign pc_d = start_go ? RESET_ADDR : pc_seq;

  // Next-state, run bookkeeping and completion detection.
  always_comb begin
    state_d  = state;
    count_d  = count;
    limit_d  = limit_q;
    done_d   = done_q;
    start_go = 1'b0;
    unique case (state)
      FS_IDLE, FS_DONE: begin
        if (start) begin
          start_go = 1'b1;
          state_d  = FS_FETCH;
          count_d  = '0;
          limit_d  = fetch_limit;
          done_d   = 1'b0;
        end
      end
      FS_FETCH: begin
        // start is ignored here, including on the final accept.
        if (accept) begin
          count_d = count + CNT_W'(1);
          if ((limit_q != '0) && (count + CNT_W'(1) == limit_q)) begin
            state_d = FS_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  // State, PC, counter and sampled limit registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset_n) begin
      state   <= FS_IDLE;
      pc      <= RESET_ADDR;
      count   <= '0;
      limit_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      count   <= count_d;
      limit_q <= limit_d;
      done_q  <= done_d;
    end
  end

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Expected fetch addresses are queued
// when a run is launched and popped whenever an accept is seen.
module tb_fetch_sequencer;
  import processor_pkg::*;

  localparam int AW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          start, start_w;
  logic [CW-1:0] fetch_limit, limit_w;
  logic          stall, fetch_ready;
  logic          branch_valid;
  logic [AW-1:0] branch_target;

  logic          fetch_valid, valid_w;
  logic [AW-1:0] fetch_address, addr_w;
  logic [CW-1:0] fetch_count, count_w;
  logic          busy, busy_w, done, done_w;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_w_q[$];

  fetch_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .fetch_limit   (fetch_limit),
    .stall         (stall),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .fetch_address (fetch_address),
    .fetch_count   (fetch_count),
    .busy          (busy),
    .done          (done),
    .branch_valid  (branch_valid),
    .branch_target (branch_target)
  );

  fetch_sequencer #(.RESET_ADDR(16'hFFFE)) dut_w (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start_w),
    .fetch_limit   (limit_w),
    .stall         (stall),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (valid_w),
    .fetch_address (addr_w),
    .fetch_count   (count_w),
    .busy          (busy_w),
    .done          (done_w),
    .branch_valid  (branch_valid),
    .branch_target (branch_target)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any accept just before the edge, return at edge + 1.
  task automatic cycle();
    @(negedge clk);
    if (fetch_valid && fetch_ready) begin
      if (exp_q.size() == 0) check("sb_extra_accept", fetch_address, 32'hFFFF_FFFF);
      else                   check("fetch_addr", fetch_address, exp_q.pop_front());
    end
    if (valid_w && fetch_ready) begin
      if (exp_w_q.size() == 0) check("sb_w_extra_accept", addr_w, 32'hFFFF_FFFF);
      else                     check("fetch_addr_w", addr_w, exp_w_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // Launch a run on the main instance and queue n sequential addresses.
  task automatic do_start(input logic [CW-1:0] lim, input int n_push);
    logic [AW-1:0] a;
    fetch_limit = lim;
    start       = 1'b1;
    for (int i = 0; i < n_push; i++) begin
      a = AW'(i);
      exp_q.push_back(a);
    end
    cycle();
    start = 1'b0;
    check("start_latency_valid", fetch_valid, 1);
    check("start_addr", fetch_address, 0);
    check("start_count", fetch_count, 0);
    check("start_done_clear", done, 0);
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    reset_n       = 1'b0;
    start         = 1'b0;
    start_w       = 1'b0;
    fetch_limit   = '0;
    limit_w       = '0;
    stall         = 1'b0;
    fetch_ready   = 1'b1;
    branch_valid  = 1'b0;
    branch_target = '0;

    // Reset state
    #12;
    check("rst_addr", fetch_address, 0);
    check("rst_count", fetch_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", fetch_valid, 0);
    check("rst_addr_w", addr_w, 16'hFFFE);
    @(posedge clk); #1;
    reset_n = 1'b1;
    stall   = 1'b1;            // stall in IDLE has no effect
    cycle();
    stall   = 1'b0;
    check("idle_stall_busy", busy, 0);

    // 1: limit 8, ready always high
    do_start(8, 8);
    for (int i = 0; i < 8; i++) cycle();
    check("t1_done", done, 1);
    check("t1_count", fetch_count, 8);
    check("t1_valid", fetch_valid, 0);
    check("t1_busy", busy, 0);
    check("t1_addr_next", fetch_address, 8);
    check("t1_sb_empty", exp_q.size(), 0);

    // 2: ready low 3 cycles at address 3; a start while busy is ignored
    do_start(8, 8);
    for (int i = 0; i < 3; i++) cycle();
    fetch_ready = 1'b0;
    start       = 1'b1;
    fetch_limit = 2;
    cycle();
    start       = 1'b0;
    cycle();
    cycle();
    check("t2_hold_addr", fetch_address, 3);
    check("t2_hold_count", fetch_count, 3);
    check("t2_hold_valid", fetch_valid, 1);
    fetch_ready = 1'b1;
    cycle();
    check("t2_resume_addr", fetch_address, 4);
    run_to_done("t2", 20);
    check("t2_count", fetch_count, 8);

    // 3: stall 2 cycles at address 5
    do_start(8, 8);
    for (int i = 0; i < 5; i++) cycle();
    stall = 1'b1;
    #1;
    check("t3_stall_valid", fetch_valid, 0);
    cycle();
    cycle();
    check("t3_stall_addr", fetch_address, 5);
    check("t3_stall_count", fetch_count, 5);
    stall = 1'b0;
    #1;
    check("t3_reissue_valid", fetch_valid, 1);
    check("t3_reissue_addr", fetch_address, 5);
    run_to_done("t3", 20);
    check("t3_count", fetch_count, 8);

`ifdef FETCH_BRANCH_EN
    // 4: branch to 0x0100 while address 2 is accepted
    do_start(8, 3);
    cycle();
    cycle();
    branch_valid  = 1'b1;
    branch_target = 16'h0100;
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h0100 + AW'(i));
    cycle();
    branch_valid  = 1'b0;
    check("t4_branch_addr", fetch_address, 16'h0100);
    check("t4_branch_count", fetch_count, 3);
    run_to_done("t4", 20);
    check("t4_count", fetch_count, 8);
`else
    // 4: branch request ignored without the feature
    do_start(4, 4);
    cycle();
    branch_valid  = 1'b1;
    branch_target = 16'h0100;
    cycle();
    branch_valid  = 1'b0;
    check("t4_nobranch_addr", fetch_address, 2);
    run_to_done("t4", 10);
`endif

    // Unlimited run: count keeps going, done stays low
    do_start(0, 20);
    for (int i = 0; i < 20; i++) cycle();
    check("lim0_done", done, 0);
    check("lim0_busy", busy, 1);
    check("lim0_count", fetch_count, 20);
    check("lim0_addr", fetch_address, 20);
    fetch_ready = 1'b0;
    reset_n     = 1'b0;
    #2;
    reset_n     = 1'b1;
    fetch_ready = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;

    // 6: async reset mid-run at address 4, then a clean restart
    do_start(8, 8);
    for (int i = 0; i < 4; i++) cycle();
    check("t6_pre_addr", fetch_address, 4);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_addr", fetch_address, 0);
    check("t6_rst_count", fetch_count, 0);
    check("t6_rst_valid", fetch_valid, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_start(2, 2);
    run_to_done("t6", 10);
    check("t6_count", fetch_count, 2);

    // 5: RESET_ADDR=FFFE, limit 3 wraps the PC
    limit_w = 3;
    start_w = 1'b1;
    exp_w_q.push_back(16'hFFFE);
    exp_w_q.push_back(16'hFFFF);
    exp_w_q.push_back(16'h0000);
    cycle();
    start_w = 1'b0;
    check("t5_start_addr", addr_w, 16'hFFFE);
    for (int i = 0; i < 3; i++) cycle();
    check("t5_done", done_w, 1);
    check("t5_count", count_w, 3);
    check("t5_addr_next", addr_w, 16'h0001);
    check("t5_sb_empty", exp_w_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_sequencer
